frame_dispatcher: RTL

- Parametrised successor to the frame scheduler: fetches 16-word frames from an internal row-organised program memory, waits on a per-frame fence, dispatches core mask, r0-init mask and r0 data, then streams instruction pairs to cores over a valid/ready channel.
- Tracks busy cores via per-core done inputs.
- Sits between the host program loader and the core array.

---
 rtl/gpu_sched_pkg.sv | 30 +++
 rtl/frame_dispatcher_if.sv | 43 ++++
 rtl/sched_prog_mem.sv | 46 ++++
 rtl/frame_dispatcher.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the frame dispatcher: FSM states, fence codes,
// header word indices and control-word field positions.
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_HDR,
    WAIT,
    RD_BODY,
    STREAM,
    HALT
  } state_e;

  // Fence codes carried in the header control word
  localparam logic [1:0] FENCE_NONE = 2'd0;
  localparam logic [1:0] FENCE_ALL  = 2'd1;

  // Header row word indices
  localparam int unsigned HDR_CTRL = 0;
  localparam int unsigned HDR_MASK = 1;
  localparam int unsigned HDR_R0V  = 2;
  localparam int unsigned HDR_R0D  = 3;

  // Control word field positions
  localparam int unsigned IFNUM_LSB = 0;
  localparam int unsigned IFNUM_W   = 6;
  localparam int unsigned FENCE_LSB = 6;
  localparam int unsigned FENCE_W   = 2;

endpackage

// File: rtl/frame_dispatcher_if.sv
// Host-load and core-array signals of the frame dispatcher.
// master: dispatcher side; slave: host loader / core array side.
interface frame_dispatcher_if #(
  parameter int unsigned NUM_CORES   = 16,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned NUM_R0      = 8,
  parameter int unsigned MEM_ROWS    = 64
) ();

  // Host program loader
  logic                                     prog_loading;
  logic                                     prog_we;
  logic [$clog2(MEM_ROWS*FRAME_WORDS)-1:0]  prog_addr;
  logic [WORD_W-1:0]                        prog_wdata;
  logic                                     start;

  // Core array
  logic [NUM_CORES-1:0]                     core_done;
  logic                                     msg_ready;
  logic [NUM_CORES-1:0]                     new_act_core;
  logic [NUM_CORES-1:0]                     init_r0_vect;
  logic [NUM_R0*WORD_W-1:0]                 r0_data;
  logic                                     dispatch_valid;
  logic [2*WORD_W-1:0]                      mess_to_core;
  logic                                     msg_valid;
  logic                                     frame_being_sent;
  logic [NUM_CORES-1:0]                     exec_mask;
  logic                                     halted;

  modport master (
    input  prog_loading, prog_we, prog_addr, prog_wdata, start, core_done, msg_ready,
    output new_act_core, init_r0_vect, r0_data, dispatch_valid, mess_to_core, msg_valid,
           frame_being_sent, exec_mask, halted
  );

  modport slave (
    output prog_loading, prog_we, prog_addr, prog_wdata, start, core_done, msg_ready,
    input  new_act_core, init_r0_vect, r0_data, dispatch_valid, mess_to_core, msg_valid,
           frame_being_sent, exec_mask, halted
  );

endinterface

// File: rtl/sched_prog_mem.sv
// Program memory: word-granular synchronous write, full-row synchronous read
// with one cycle of latency. A same-cycle read of a row being written returns
// the old row. Contents are not reset.
module sched_prog_mem #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned MEM_ROWS    = 64
) (
  input  logic                                    clk,
  input  logic                                    we,
  input  logic [$clog2(MEM_ROWS*FRAME_WORDS)-1:0] waddr,
  input  logic [WORD_W-1:0]                       wdata,
  input  logic                                    re,
  input  logic [$clog2(MEM_ROWS)-1:0]             raddr,
  output logic [FRAME_WORDS*WORD_W-1:0]           rdata
);

  localparam int unsigned SelW  = $clog2(FRAME_WORDS);
  localparam int unsigned AddrW = $clog2(MEM_ROWS*FRAME_WORDS);
  localparam int unsigned RowW  = FRAME_WORDS * WORD_W;

  logic [RowW-1:0]             mem_q [MEM_ROWS];
  logic [RowW-1:0]             rdata_q;
  logic [AddrW-SelW-1:0]       w_row;
  logic [SelW-1:0]             w_sel;

  assign w_row = waddr[AddrW-1:SelW];
  assign w_sel = waddr[SelW-1:0];

  // Word write into the addressed row
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[w_row][int'(w_sel)*WORD_W +: WORD_W] <= wdata;
    end
  end

  // Registered full-row read; holds its value between reads
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_dispatcher.sv
// Frame dispatcher: walks the program memory row by row, waits on each frame's
// fence, dispatches the core/r0 masks and r0 data, then streams the body rows
// to the cores as word pairs over a valid/ready channel.
// Optional macro FRAME_DISPATCH_PERF_EN adds stall_cycles / frames_done counters.
module frame_dispatcher
  import gpu_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 16,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned FRAME_WORDS = 16,
  parameter int unsigned NUM_R0      = 8,
  parameter int unsigned MEM_ROWS    = 64
) (
  input  logic               clk,
  input  logic               reset,
  frame_dispatcher_if.master bus
`ifdef FRAME_DISPATCH_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        frames_done
`endif
);

  localparam int unsigned RowW  = FRAME_WORDS * WORD_W;
  localparam int unsigned PtrW  = $clog2(MEM_ROWS);
  localparam int unsigned Pairs = FRAME_WORDS / 2;
  localparam int unsigned PairW = $clog2(Pairs);

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [IFNUM_W-1:0]    rows_left_q, rows_left_d;
  logic [PairW-1:0]      pair_q, pair_d;
  logic [NUM_CORES-1:0]  exec_mask_q, exec_mask_d;

  logic [RowW-1:0]       row_data;
  logic [IFNUM_W-1:0]    if_num;
  logic [FENCE_W-1:0]    fence;
  logic [NUM_CORES-1:0]  hdr_mask;
  logic [NUM_CORES-1:0]  hdr_r0v;
  logic [NUM_R0*WORD_W-1:0] hdr_r0d;
  logic [2*WORD_W-1:0]   cur_pair;
  logic                  hdr_live, fence_ok, dispatch, handshake, last_pair, rd_en;

  sched_prog_mem #(
    .WORD_W      (WORD_W),
    .FRAME_WORDS (FRAME_WORDS),
    .MEM_ROWS    (MEM_ROWS)
  ) u_mem (
    .clk   (clk),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_wdata),
    .re    (rd_en),
    .raddr (ptr_q),
    .rdata (row_data)
  );

  // Header fields decoded straight from the registered row
  assign if_num    = row_data[HDR_CTRL*WORD_W + IFNUM_LSB +: IFNUM_W];
  assign fence     = row_data[HDR_CTRL*WORD_W + FENCE_LSB +: FENCE_W];
  assign hdr_mask  = row_data[HDR_MASK*WORD_W +: NUM_CORES];
  assign hdr_r0v   = row_data[HDR_R0V*WORD_W +: NUM_CORES];
  assign hdr_r0d   = row_data[HDR_R0D*WORD_W +: NUM_R0*WORD_W];
  assign cur_pair  = row_data[int'(pair_q)*(2*WORD_W) +: 2*WORD_W];

  // Any non-zero fence code waits for the whole array to drain
  assign hdr_live  = (if_num != '0);
  assign fence_ok  = (fence == FENCE_NONE) ? ((exec_mask_q & hdr_mask) == '0)
                                           : (exec_mask_q == '0);
  assign dispatch  = (state_q == WAIT) && hdr_live && fence_ok;
  assign handshake = (state_q == STREAM) && bus.msg_ready;
  assign last_pair = (pair_q == PairW'(Pairs - 1));
  assign rd_en     = (state_q == RD_HDR) || (state_q == RD_BODY);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rows_left_q <= '0;
      pair_q      <= '0;
      exec_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rows_left_q <= rows_left_d;
      pair_q      <= pair_d;
      exec_mask_q <= exec_mask_d;
    end
  end

  // Next-state logic; a host load aborts from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RD_HDR;
      RD_HDR:  state_d = WAIT;
      WAIT: begin
        if (!hdr_live)     state_d = HALT;
        else if (fence_ok) state_d = RD_BODY;
      end
      RD_BODY: state_d = STREAM;
      STREAM: begin
        if (handshake && last_pair) begin
          state_d = (rows_left_q == IFNUM_W'(1)) ? RD_HDR : RD_BODY;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (bus.prog_loading) state_d = IDLE;
  end

  // Row pointer, remaining-row count, pair index and busy-core tracking
  always_comb begin
    ptr_d       = ptr_q;
    rows_left_d = rows_left_q;
    pair_d      = pair_q;
    if (state_q == IDLE)    ptr_d  = '0;
    if (state_q == RD_BODY) pair_d = '0;
    if (dispatch) begin
      ptr_d       = ptr_q + 1'b1;
      rows_left_d = if_num;
    end
    if (handshake) begin
      if (last_pair) begin
        pair_d      = '0;
        rows_left_d = rows_left_q - 1'b1;
        ptr_d       = ptr_q + 1'b1;
      end else begin
        pair_d = pair_q + 1'b1;
      end
    end
    if (bus.prog_loading) begin
      ptr_d  = '0;
      pair_d = '0;
    end
    // Dispatch set is applied after the done-clear so it wins a collision
    exec_mask_d = (exec_mask_q & ~bus.core_done) | (dispatch ? hdr_mask : '0);
  end

  // Outputs decoded from state; dispatch fields read as zero outside the pulse
  always_comb begin
    bus.dispatch_valid   = dispatch;
    bus.new_act_core     = dispatch ? hdr_mask : '0;
    bus.init_r0_vect     = dispatch ? hdr_r0v  : '0;
    bus.r0_data          = dispatch ? hdr_r0d  : '0;
    bus.msg_valid        = (state_q == STREAM);
    bus.mess_to_core     = (state_q == STREAM) ? cur_pair : '0;
    bus.frame_being_sent = (state_q == STREAM);
    bus.exec_mask        = exec_mask_q;
    bus.halted           = (state_q == HALT);
  end

`ifdef FRAME_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] frames_q, frames_d;
  logic        stall_inc, frame_end;

  assign stall_inc = ((state_q == WAIT) && hdr_live && !fence_ok) ||
                     ((state_q == STREAM) && !bus.msg_ready);
  assign frame_end = handshake && last_pair && (rows_left_q == IFNUM_W'(1));

  // Saturating performance counters
  always_comb begin
    stall_d  = stall_q;
    frames_d = frames_q;
    if (stall_inc && (stall_q != '1))  stall_d  = stall_q + 1'b1;
    if (frame_end && (frames_q != '1)) frames_d = frames_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      frames_q <= '0;
    end else begin
      stall_q  <= stall_d;
      frames_q <= frames_d;
    end
  end

  assign stall_cycles = stall_q;
  assign frames_done  = frames_q;
`endif

endmodule
